// File: rtl/parity_rr_sched.sv
// ---------------------------------------------------------------------------
// parity_rr_sched
//
// Shares one 4-bit XOR-reduction parity datapath among NREQ nibble-stream
// requesters. A round-robin arbiter picks a requester, which then owns the
// datapath for a multi-beat transaction (one nibble per beat) until its last
// beat. The accumulated parity is returned on a single valid/ready response
// channel, tagged with the requester id and the saturating beat count.
//
// Parameters:
//   NREQ  number of requesters (2..16)
//   IDW   requester id width, ceil(log2(NREQ))
//   CNTW  beat counter width (saturates at 2^CNTW-1)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester beat valid                      [NREQ]
//   req_data    nibble per requester, req i at [4i+3:4i]      [4*NREQ]
//   req_last    final beat of a transaction                   [NREQ]
//   req_ready   per-requester beat accept                     [NREQ]
//   rsp_valid   response valid
//   rsp_ready   response accept
//   rsp_parity  XOR of all bits of all beats of the transaction
//   rsp_id      granted requester index                       [IDW]
//   rsp_beats   beats accepted, saturating                    [CNTW]
//
// Optional build macro PARITY_RR_STATS_EN adds:
//   stat_xfers  completed responses, wraps modulo 2^16        [16]
//   stat_odd    completed responses with odd parity           [16]
// ---------------------------------------------------------------------------
module parity_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_parity,
    output logic [IDW-1:0]    rsp_id,
    output logic [CNTW-1:0]   rsp_beats
`ifdef PARITY_RR_STATS_EN
    ,
    output logic [15:0]       stat_xfers,
    output logic [15:0]       stat_odd
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic            acc_q, acc_d;
    logic [CNTW-1:0] beats_q, beats_d;
    logic            rsp_valid_q, rsp_valid_d;

    // Arbitration result and granted-requester view of the inputs.
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] gnt_onehot;
    logic            cur_valid;
    logic            cur_last;
    logic [3:0]      cur_nib;
    logic [IDW-1:0]  gnt_next;

    // Round-robin pick: first valid requester scanning ptr, ptr+1, ...
    // wrapping modulo NREQ (not modulo 2^IDW, so NREQ need not be a power of 2).
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'(idx);
            end
        end
    end

    // Mux the granted requester's beat signals out of the packed buses.
    always_comb begin
        gnt_onehot = '0;
        cur_valid  = 1'b0;
        cur_last   = 1'b0;
        cur_nib    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q == IDW'(i)) begin
                gnt_onehot[i] = 1'b1;
                cur_valid     = req_valid[i];
                cur_last      = req_last[i];
                cur_nib       = req_data[4*i +: 4];
            end
        end
    end

    assign gnt_next = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    acc_d   = 1'b0;
                    beats_d = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                req_ready = gnt_onehot;
                if (cur_valid) begin
                    acc_d = acc_q ^ (^cur_nib);
                    if (beats_q != '1) begin
                        beats_d = beats_q + CNTW'(1);
                    end
                    if (cur_last) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    ptr_d       = gnt_next;
                end
            end

            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            acc_q       <= 1'b0;
            beats_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Response fields come straight from the accumulator flops; they only
    // change in IDLE/BUSY, so they hold still for the whole RESP phase.
    assign rsp_valid  = rsp_valid_q;
    assign rsp_parity = acc_q;
    assign rsp_id     = gnt_q;
    assign rsp_beats  = beats_q;

`ifdef PARITY_RR_STATS_EN
    logic [15:0] stat_xfers_q, stat_xfers_d;
    logic [15:0] stat_odd_q, stat_odd_d;

    always_comb begin
        stat_xfers_d = stat_xfers_q;
        stat_odd_d   = stat_odd_q;
        if (rsp_valid_q && rsp_ready) begin
            stat_xfers_d = stat_xfers_q + 16'd1;
            if (acc_q) begin
                stat_odd_d = stat_odd_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_xfers_q <= '0;
            stat_odd_q   <= '0;
        end else begin
            stat_xfers_q <= stat_xfers_d;
            stat_odd_q   <= stat_odd_d;
        end
    end

    assign stat_xfers = stat_xfers_q;
    assign stat_odd   = stat_odd_q;
`endif

endmodule

// File: tb/tb_parity_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_parity_rr_sched
//
// Self-checking bench for parity_rr_sched. The main instance uses default
// parameters; a second instance with CNTW=2 exercises beat-count saturation.
// Expected responses are pushed to a scoreboard queue when stimulus is driven
// and popped when the DUT presents a response.
// ---------------------------------------------------------------------------
module tb_parity_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [15:0] req_data;
    logic        rsp_valid, rsp_ready, rsp_parity;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_beats;

    logic [3:0]  s_req_valid, s_req_last, s_req_ready;
    logic [15:0] s_req_data;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_parity;
    logic [1:0]  s_rsp_id;
    logic [1:0]  s_rsp_beats;

`ifdef PARITY_RR_STATS_EN
    logic [15:0] stat_xfers, stat_odd, s_stat_xfers, s_stat_odd;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       par;
        logic [1:0] id;
        logic [7:0] beats;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    parity_rr_sched #(.NREQ(4), .IDW(2), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_parity(rsp_parity),
        .rsp_id(rsp_id), .rsp_beats(rsp_beats)
`ifdef PARITY_RR_STATS_EN
        , .stat_xfers(stat_xfers), .stat_odd(stat_odd)
`endif
    );

    parity_rr_sched #(.NREQ(4), .IDW(2), .CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_data(s_req_data), .req_last(s_req_last),
        .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_parity(s_rsp_parity),
        .rsp_id(s_rsp_id), .rsp_beats(s_rsp_beats)
`ifdef PARITY_RR_STATS_EN
        , .stat_xfers(s_stat_xfers), .stat_odd(s_stat_odd)
`endif
    );

    // Reference parity: XOR of every bit of the first n nibbles.
    function automatic logic model_par(input logic [31:0] nibs, input int n);
        logic p;
        p = 1'b0;
        for (int b = 0; b < n; b++) p = p ^ (^nibs[4*b +: 4]);
        return p;
    endfunction

    // Wait (bounded) for the main DUT to present a response.
    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Present n nibbles (nibble b at nibs[4b+3:4b]) from requester id, one
    // per accepted beat; last is raised on the final one.
    task automatic drive_txn(input int id, input logic [31:0] nibs, input int n,
                             output bit to);
        bit seen;
        to = 1'b0;
        for (int b = 0; b < n; b++) begin
            req_valid[id]       = 1'b1;
            req_data[4*id +: 4] = nibs[4*b +: 4];
            req_last[id]        = (b == n - 1);
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (req_ready[id] === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        rsp_ready   = 1'b1;
        s_req_valid = '0;
        s_req_last  = '0;
        s_req_data  = '0;
        s_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_parity, rsp_id, rsp_beats, req_ready} !== 16'h0) begin
            bad++;
            $display("FAIL reset_values: got valid=%b par=%b id=%0d beats=%0d ready=%b, want all 0",
                     rsp_valid, rsp_parity, rsp_id, rsp_beats, req_ready);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
                bad++;
                $display("FAIL idle_quiet cycle %0d: got valid=%b ready=%b, want 0/0000",
                         c, rsp_valid, req_ready);
            end
        end
    endtask

    task automatic test_single_beat();
        bit   to;
        exp_t e;
        sb.push_back('{par: model_par(32'hB, 1), id: 2'd2, beats: 8'd1});
        drive_txn(2, 32'hB, 1, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL single_drive: got timeout, want beat accepted");
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: got rsp_valid=%b one cycle after beat, want 1", rsp_valid);
        end
        e = sb.pop_front();
        total++;
        if ({rsp_parity, rsp_id, rsp_beats} !== {e.par, e.id, e.beats}) begin
            bad++;
            $display("FAIL single_rsp: got par=%b id=%0d beats=%0d, want par=%b id=%0d beats=%0d",
                     rsp_parity, rsp_id, rsp_beats, e.par, e.id, e.beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_busy();
        bit   seen, got;
        exp_t e;
        // Pointer is now 3; requester 2 alone is granted, one beat accepted.
        req_valid[2]    = 1'b1;
        req_data[11:8]  = 4'h1;
        req_last[2]     = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[2] === 1'b1) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (!seen || req_ready !== 4'b0100 || rsp_id !== 2'd2) begin
            bad++;
            $display("FAIL busy_before_reset: got seen=%b ready=%b id=%0d, want 1/0100/2",
                     seen, req_ready, rsp_id);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({rsp_valid, rsp_parity, rsp_id, rsp_beats, req_ready} !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_busy: got valid=%b par=%b id=%0d beats=%0d ready=%b, want all 0",
                     rsp_valid, rsp_parity, rsp_id, rsp_beats, req_ready);
        end
        req_valid = '0;
        req_last  = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // All requesters valid: pointer back at 0 means requester 0 wins.
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 16'h1370;
        sb.push_back('{par: 1'b0, id: 2'd0, beats: 8'd1});
        wait_rsp(got);
        req_valid = '0;
        req_last  = '0;
        e = sb.pop_front();
        total++;
        if (!got || {rsp_parity, rsp_id, rsp_beats} !== {e.par, e.id, e.beats}) begin
            bad++;
            $display("FAIL ptr_after_reset: got rsp=%b par=%b id=%0d beats=%0d, want par=%b id=%0d beats=%0d",
                     got, rsp_parity, rsp_id, rsp_beats, e.par, e.id, e.beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_multi_beat();
        bit   to, got;
        exp_t e;
        sb.push_back('{par: model_par(32'h31F, 3), id: 2'd0, beats: 8'd3});
        drive_txn(0, 32'h31F, 3, to);
        wait_rsp(got);
        e = sb.pop_front();
        total++;
        if (to || !got || {rsp_parity, rsp_id, rsp_beats} !== {e.par, e.id, e.beats}) begin
            bad++;
            $display("FAIL multi_beat: got to=%b rsp=%b par=%b id=%0d beats=%0d, want par=%b id=%0d beats=%0d",
                     to, got, rsp_parity, rsp_id, rsp_beats, e.par, e.id, e.beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit   to, got;
        exp_t e;
        rsp_ready = 1'b0;
        sb.push_back('{par: model_par(32'h37, 2), id: 2'd1, beats: 8'd2});
        drive_txn(1, 32'h37, 2, to);
        wait_rsp(got);
        // A competing requester appears while the response is stalled.
        req_valid[3]    = 1'b1;
        req_data[15:12] = 4'h8;
        req_last[3]     = 1'b1;
        e = sb.pop_front();
        total++;
        if (to || !got || {rsp_parity, rsp_id, rsp_beats} !== {e.par, e.id, e.beats}) begin
            bad++;
            $display("FAIL bp_rsp: got to=%b rsp=%b par=%b id=%0d beats=%0d, want par=%b id=%0d beats=%0d",
                     to, got, rsp_parity, rsp_id, rsp_beats, e.par, e.id, e.beats);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || req_ready !== 4'b0 ||
                {rsp_parity, rsp_id, rsp_beats} !== {e.par, e.id, e.beats}) begin
                bad++;
                $display("FAIL bp_stable cycle %0d: got valid=%b ready=%b par=%b id=%0d beats=%0d, want 1/0000 par=%b id=%0d beats=%0d",
                         c, rsp_valid, req_ready, rsp_parity, rsp_id, rsp_beats, e.par, e.id, e.beats);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
            bad++;
            $display("FAIL bp_release_idle: got valid=%b ready=%b, want 0/0000", rsp_valid, req_ready);
        end
        // Pointer moved past requester 1, so requester 3 is served next.
        sb.push_back('{par: 1'b1, id: 2'd3, beats: 8'd1});
        drive_txn(3, 32'h8, 1, to);
        wait_rsp(got);
        e = sb.pop_front();
        total++;
        if (to || !got || {rsp_parity, rsp_id, rsp_beats} !== {e.par, e.id, e.beats}) begin
            bad++;
            $display("FAIL bp_next_grant: got to=%b rsp=%b par=%b id=%0d beats=%0d, want par=%b id=%0d beats=%0d",
                     to, got, rsp_parity, rsp_id, rsp_beats, e.par, e.id, e.beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        bit   got;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 16'h1370;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] want_id;
            want_id = 2'(i % 4);
            sb.push_back('{par: ^req_data[4*want_id +: 4], id: want_id, beats: 8'd1});
        end
        for (int i = 0; i < 5; i++) begin
            wait_rsp(got);
            if (i == 4) begin
                req_valid = '0;
                req_last  = '0;
            end
            e = sb.pop_front();
            total++;
            if (!got || {rsp_parity, rsp_id, rsp_beats} !== {e.par, e.id, e.beats}) begin
                bad++;
                $display("FAIL rr_order #%0d: got rsp=%b par=%b id=%0d beats=%0d, want par=%b id=%0d beats=%0d",
                         i, got, rsp_parity, rsp_id, rsp_beats, e.par, e.id, e.beats);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturation();
        logic [31:0] nibs;
        bit          seen, to, got;
        nibs = 32'h0073_8421;
        to   = 1'b0;
        for (int b = 0; b < 6; b++) begin
            s_req_valid[1]   = 1'b1;
            s_req_data[7:4]  = nibs[4*b +: 4];
            s_req_last[1]    = (b == 5);
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (s_req_ready[1] === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_req_valid = '0;
        s_req_last  = '0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (s_rsp_valid === 1'b1) got = 1'b1;
        end
        total++;
        if (to || !got || s_rsp_beats !== 2'd3 || s_rsp_id !== 2'd1 ||
            s_rsp_parity !== model_par(nibs, 6)) begin
            bad++;
            $display("FAIL saturation: got to=%b rsp=%b beats=%0d id=%0d par=%b, want beats=3 id=1 par=%b",
                     to, got, s_rsp_beats, s_rsp_id, s_rsp_parity, model_par(nibs, 6));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_reset_mid_busy();
        test_multi_beat();
        test_backpressure();
        test_round_robin();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
